// File: rtl/regrd_pkg.sv
// rtl/regrd_pkg.sv - shared types and constants for the register-file sweep reader
//
// Purpose: FSM state encoding, default handshake timeout and the idle-address
//          helper used by regfile_sweep_reader.
// Ports:   none (package).
package regrd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  localparam int DEF_ACK_TIMEOUT = 255;

  // Widest r_addr the idle-address helper can describe.
  localparam int MAX_ADDR_W = 16;

  // All-ones code of width addr_w, right-aligned; callers truncate to their own width.
  function automatic logic [MAX_ADDR_W-1:0] idle_addr(input int addr_w);
    logic [MAX_ADDR_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_ADDR_W; i++) begin
      if (i < addr_w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - 1-bit multi-flop synchroniser
//
// Purpose: brings an asynchronous level into the clk domain through STAGES flops.
// Ports:
//   clk    in  1  clock
//   n_rst  in  1  asynchronous active-low reset (chain clears to 0)
//   d      in  1  asynchronous input level
//   q      out 1  last flop of the chain
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/regfile_sweep_reader.sv
// rtl/regfile_sweep_reader.sv - sweeps NUM_REGS registers over a 4-phase handshake
//
// Purpose: on each synchronised rising edge of done, reads registers 0..NUM_REGS-1
//          with a full r_en/ren_ack handshake per register into a shadow copy, then
//          commits the whole set to cfg_regs in one cycle.
// Optional feature: define REGRD_TIMEOUT_EN to abort a handshake phase that stalls
//          for ACK_TIMEOUT cycles (sets sticky rd_err, no commit).
// Ports:
//   clk         in  1                 clock
//   n_rst       in  1                 asynchronous active-low reset
//   done        in  1                 async level; 0->1 requests a sweep
//   ren_ack     in  1                 async ack from the register file
//   r_data      in  DATA_W            read data, stable while ren_ack=1
//   r_en        out 1                 read request
//   r_addr      out ADDR_W            read address, all-ones when idle
//   done_sync   out 1                 synchronised done
//   busy        out 1                 sweep in progress
//   sweep_done  out 1                 1-cycle pulse on commit
//   cfg_valid   out 1                 sticky, set by first commit
//   cfg_regs    out NUM_REGS*DATA_W   slot k at [k*DATA_W +: DATA_W]
//   rd_err      out 1                 sticky timeout flag (0 without REGRD_TIMEOUT_EN)
module regfile_sweep_reader
  import regrd_pkg::*;
#(
  parameter int NUM_REGS    = 2,
  parameter int DATA_W      = 3,
  parameter int ADDR_W      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       done,
  input  logic                       ren_ack,
  input  logic [DATA_W-1:0]          r_data,
  output logic                       r_en,
  output logic [ADDR_W-1:0]          r_addr,
  output logic                       done_sync,
  output logic                       busy,
  output logic                       sweep_done,
  output logic                       cfg_valid,
  output logic [NUM_REGS*DATA_W-1:0] cfg_regs,
  output logic                       rd_err
);

  localparam int                CFG_W     = NUM_REGS * DATA_W;
  localparam logic [ADDR_W-1:0] ADDR_IDLE = ADDR_W'(idle_addr(ADDR_W));
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_REGS - 1);

  // The idle code must never collide with a data address.
  generate
    if (NUM_REGS < 1 || NUM_REGS >= (1 << ADDR_W) || ADDR_W > MAX_ADDR_W ||
        SYNC_STAGES < 2 || ACK_TIMEOUT < 1) begin : g_param_check
      $error("regfile_sweep_reader: illegal parameter combination");
    end
  endgenerate

  logic       done_s;
  logic       done_s_d;
  logic       ack_s;
  logic       start;
  logic       pending;
  state_t     state;
  logic [CFG_W-1:0] shadow;

  sync_ff #(.STAGES(SYNC_STAGES)) u_done_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (done),
    .q     (done_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (ren_ack),
    .q     (ack_s)
  );

  assign done_sync = done_s;
  assign start     = done_s & ~done_s_d;

`ifdef REGRD_TIMEOUT_EN
  localparam int             TMO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             stall;

  // The handshake is waiting on the responder in the current phase.
  assign stall = (state == REQ && !ack_s) || (state == REL && ack_s);
`else
  assign rd_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      r_en       <= 1'b0;
      r_addr     <= ADDR_IDLE;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      cfg_valid  <= 1'b0;
      cfg_regs   <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      done_s_d   <= 1'b0;
`ifdef REGRD_TIMEOUT_EN
      tmo_cnt    <= '0;
      rd_err     <= 1'b0;
`endif
    end else begin
      done_s_d   <= done_s;
      sweep_done <= 1'b0;

      // A request that arrives mid-sweep (including the commit cycle) is
      // remembered once; further edges merge into it.
      if (start && state != IDLE) pending <= 1'b1;

`ifdef REGRD_TIMEOUT_EN
      // Counter restarts whenever the phase makes progress or the state changes.
      if (stall) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else       tmo_cnt <= '0;

      if (stall && tmo_cnt == TMO_LAST) begin
        state   <= IDLE;
        r_en    <= 1'b0;
        rd_err  <= 1'b1;
        r_addr  <= ADDR_IDLE;
        busy    <= 1'b0;
        pending <= 1'b0;
        tmo_cnt <= '0;
      end else
`endif
      begin
        case (state)
          IDLE: begin
            if (start || pending) begin
              state   <= REQ;
              r_addr  <= '0;
              r_en    <= 1'b1;
              busy    <= 1'b1;
              pending <= 1'b0;
            end
          end

          REQ: begin
            if (ack_s) begin
              for (int k = 0; k < NUM_REGS; k++) begin
                if (r_addr == ADDR_W'(k)) shadow[k*DATA_W +: DATA_W] <= r_data;
              end
              r_en  <= 1'b0;
              state <= REL;
            end
          end

          REL: begin
            if (!ack_s) begin
              if (r_addr < ADDR_LAST) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_en   <= 1'b1;
                state  <= REQ;
              end else begin
                // shadow already holds the last slot, captured in REQ.
                cfg_regs   <= shadow;
                sweep_done <= 1'b1;
                cfg_valid  <= 1'b1;
                busy       <= 1'b0;
                r_addr     <= ADDR_IDLE;
                state      <= IDLE;
              end
            end
          end

          default: begin
            state  <= IDLE;
            r_en   <= 1'b0;
            r_addr <= ADDR_IDLE;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
